// File: rtl/frame_renderer.sv
// rtl/frame_renderer.sv - tile map and sprite renderer producing VGA raster with 2-stage pixel pipeline
module frame_renderer #(
  parameter int BDR             = 0,
  parameter int SKY             = 1,
  parameter int BLK             = 2,
  parameter int GND             = 3,
  parameter int TKN             = 4,
  parameter int CK1             = 5,
  parameter int CK2             = 6,
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33
) (
  input  logic                     vga_clock,
  input  logic                     reset,
  input  logic [11:0][16:0][7:0]   background,
  input  logic signed [31:0]       mario_x,
  input  logic signed [31:0]       mario_y,
  input  logic signed [31:0]       goomba_x,
  input  logic signed [31:0]       goomba_y,
  input  logic signed [31:0]       goomba_2x,
  input  logic signed [31:0]       goomba_2y,
  output logic [11:0]              rgb,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     frame_start
);

  localparam int H_TOTAL = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(SCREEN_WIDTH);
  localparam logic [9:0] V_VIS    = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] HS_START = 10'(SCREEN_WIDTH + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(SCREEN_WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(SCREEN_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [9:0] BW       = 10'(BLOCK_WIDTH);

  localparam logic signed [31:0] SPR_W    = 32'(CHARACTER_WIDTH);
  localparam logic signed [31:0] OFF_SCRN = 32'sd1000;

  // Square hit test in signed pixel space; off-screen corners clip naturally.
  function automatic logic sprite_hit(input logic signed [31:0] x, input logic signed [31:0] y,
                                      input logic signed [31:0] h, input logic signed [31:0] v);
    return (x <= h) && (h < x + SPR_W) && (y <= v) && (v < y + SPR_W);
  endfunction

  // Raster counters
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  // Per-frame sprite snapshot
  logic signed [31:0] mario_x_q, mario_y_q, goomba_x_q, goomba_y_q, goomba_2x_q, goomba_2y_q;
  logic               frame_start_q;

  // Stage 1 registers
  logic       valid1_q;
  logic       visible1_q;
  logic       hsync1_q;
  logic       vsync1_q;
  logic [7:0] tile1_q;
  logic       mario_hit1_q;
  logic       goomba_hit1_q;

  // Stage 2 registers
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q;
  logic        vsync_q;

  // Stage 0 terms
  logic               visible0;
  logic               hsync0;
  logic               vsync0;
  logic               snap_now;
  logic signed [31:0] h_pos;
  logic signed [31:0] v_pos;
  logic [9:0]         col_full;
  logic [9:0]         row_full;
  logic [4:0]         col_idx;
  logic [3:0]         row_idx;
  logic [7:0]         tile_d;

  assign visible0 = (hcount_q < H_VIS) && (vcount_q < V_VIS);
  assign hsync0   = !((hcount_q >= HS_START) && (hcount_q < HS_END));
  assign vsync0   = !((vcount_q >= VS_START) && (vcount_q < VS_END));
  assign snap_now = (hcount_q == 10'd0) && (vcount_q == V_VIS);
  assign h_pos    = signed'({22'd0, hcount_q});
  assign v_pos    = signed'({22'd0, vcount_q});

  // Next raster position: wrap at end of line, then at end of frame
  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 10'd0;
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end
  end

  // Tile address; clamped in blanking so the index stays inside the map (result is unused there)
  always_comb begin
    col_full = hcount_q / BW;
    row_full = vcount_q / BW;
    col_idx  = (col_full > 10'd16) ? 5'd0 : 5'd16 - col_full[4:0];
    row_idx  = (row_full > 10'd11) ? 4'd0 : 4'd11 - row_full[3:0];
    tile_d   = background[row_idx][col_idx];
  end

  // Raster counter register
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Sprite snapshot at the first blank line so a frame never shows a half-moved sprite
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      mario_x_q     <= OFF_SCRN;
      mario_y_q     <= OFF_SCRN;
      goomba_x_q    <= OFF_SCRN;
      goomba_y_q    <= OFF_SCRN;
      goomba_2x_q   <= OFF_SCRN;
      goomba_2y_q   <= OFF_SCRN;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= snap_now;
      if (snap_now) begin
        mario_x_q   <= mario_x;
        mario_y_q   <= mario_y;
        goomba_x_q  <= goomba_x;
        goomba_y_q  <= goomba_y;
        goomba_2x_q <= goomba_2x;
        goomba_2y_q <= goomba_2y;
      end
    end
  end

  // Stage 1: tile lookup, sprite hits, sync carried alongside
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      valid1_q      <= 1'b0;
      visible1_q    <= 1'b0;
      hsync1_q      <= 1'b1;
      vsync1_q      <= 1'b1;
      tile1_q       <= 8'd0;
      mario_hit1_q  <= 1'b0;
      goomba_hit1_q <= 1'b0;
    end else begin
      valid1_q      <= 1'b1;
      visible1_q    <= visible0;
      hsync1_q      <= hsync0;
      vsync1_q      <= vsync0;
      tile1_q       <= tile_d;
      mario_hit1_q  <= sprite_hit(mario_x_q, mario_y_q, h_pos, v_pos);
      goomba_hit1_q <= sprite_hit(goomba_x_q, goomba_y_q, h_pos, v_pos) ||
                       sprite_hit(goomba_2x_q, goomba_2y_q, h_pos, v_pos);
    end
  end

  // Colour selection: blanking, then mario, then goombas, then tile palette
  always_comb begin
    rgb_d = 12'h000;
    if (valid1_q && visible1_q) begin
      if (mario_hit1_q) begin
        rgb_d = 12'hF00;
      end else if (goomba_hit1_q) begin
        rgb_d = 12'h840;
      end else begin
        case (tile1_q)
          8'(BDR): rgb_d = 12'h000;
          8'(SKY): rgb_d = 12'h5AF;
          8'(BLK): rgb_d = 12'hA52;
          8'(GND): rgb_d = 12'h630;
          8'(TKN): rgb_d = 12'hFD0;
          8'(CK1): rgb_d = 12'hFFF;
          8'(CK2): rgb_d = 12'h888;
          default: rgb_d = 12'hF0F;
        endcase
      end
    end
  end

  // Stage 2: output registers, sync delayed to match the pixel
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= valid1_q ? hsync1_q : 1'b1;
      vsync_q <= valid1_q ? vsync1_q : 1'b1;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_frame_renderer.sv
// tb/tb_frame_renderer.sv - randomized bench for frame_renderer against a raster reference model
module tb_frame_renderer;

  localparam int SW    = 120;
  localparam int SH    = 90;
  localparam int HFP   = 4;
  localparam int HS    = 8;
  localparam int HBP   = 4;
  localparam int VFP   = 2;
  localparam int VS    = 2;
  localparam int VBP   = 2;
  localparam int HT    = SW + HFP + HS + HBP;
  localparam int VT    = SH + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int CW    = 42;
  localparam int BWID  = 40;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [11:0][16:0][7:0] bg;
  int                     mx, my, gx, gy, g2x, g2y;
  logic [11:0]            rgb;
  logic                   hsync, vsync, frame_start;

  frame_renderer #(
    .SCREEN_WIDTH (SW),  .SCREEN_HEIGHT(SH),
    .H_FRONT      (HFP), .H_SYNC       (HS), .H_BACK(HBP),
    .V_FRONT      (VFP), .V_SYNC       (VS), .V_BACK(VBP)
  ) dut (
    .vga_clock  (clk),
    .reset      (reset),
    .background (bg),
    .mario_x    (mx),
    .mario_y    (my),
    .goomba_x   (gx),
    .goomba_y   (gy),
    .goomba_2x  (g2x),
    .goomba_2y  (g2y),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          t = 0;
  int          snap[6];
  logic [11:0] d1_rgb, d2_rgb;
  bit          d1_hs, d2_hs, d1_vs, d2_vs;
  bit          fs_next = 1'b0;
  bit          window = 1'b1;
  int          hs_low = 0, vs_low = 0, fs_cnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
    end
  endtask

  function automatic logic [11:0] palette(input logic [7:0] code);
    case (code)
      8'd0:    return 12'h000;
      8'd1:    return 12'h5AF;
      8'd2:    return 12'hA52;
      8'd3:    return 12'h630;
      8'd4:    return 12'hFD0;
      8'd5:    return 12'hFFF;
      8'd6:    return 12'h888;
      default: return 12'hF0F;
    endcase
  endfunction

  function automatic bit in_sq(input int x, input int y, input int h, input int v);
    return (h >= x) && (h < x + CW) && (v >= y) && (v < y + CW);
  endfunction

  function automatic logic [11:0] pix(input int h, input int v);
    if (h >= SW || v >= SH) return 12'h000;
    if (in_sq(snap[0], snap[1], h, v)) return 12'hF00;
    if (in_sq(snap[2], snap[3], h, v) || in_sq(snap[4], snap[5], h, v)) return 12'h840;
    return palette(bg[11 - v / BWID][16 - h / BWID]);
  endfunction

  task automatic check_outputs();
    @(negedge clk);
    if (t < 2) begin
      chk("rgb", int'(rgb), 0);
      chk("hsync", int'(hsync), 1);
      chk("vsync", int'(vsync), 1);
    end else begin
      chk("rgb", int'(rgb), int'(d2_rgb));
      chk("hsync", int'(hsync), int'(d2_hs));
      chk("vsync", int'(vsync), int'(d2_vs));
    end
    chk("frame_start", int'(frame_start), int'(fs_next));
    if (window && t >= 2 && t < FRAME + 2) begin
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (frame_start) fs_cnt++;
    end
  endtask

  task automatic advance(input bit rst);
    int h, v;
    if (rst) begin
      reset = 1'b1;
      t = 0;
      fs_next = 1'b0;
      for (int i = 0; i < 6; i++) snap[i] = 1000;
      return;
    end
    reset = 1'b0;
    h = t % HT;
    v = (t / HT) % VT;
    d2_rgb = d1_rgb;
    d2_hs  = d1_hs;
    d2_vs  = d1_vs;
    d1_rgb = pix(h, v);
    d1_hs  = !(h >= SW + HFP && h < SW + HFP + HS);
    d1_vs  = !(v >= SH + VFP && v < SH + VFP + VS);
    fs_next = (h == 0 && v == SH);
    if (fs_next) begin
      snap[0] = mx;  snap[1] = my;
      snap[2] = gx;  snap[3] = gy;
      snap[4] = g2x; snap[5] = g2y;
    end
    t++;
  endtask

  task automatic mutate();
    int r, c;
    r = 9 + int'($urandom_range(2));
    c = 14 + int'($urandom_range(2));
    bg[r][c] = 8'($urandom_range(7));
  endtask

  initial begin
    for (int i = 0; i < 6; i++) snap[i] = 1000;
    d1_rgb = '0; d2_rgb = '0;
    d1_hs = 1'b1; d2_hs = 1'b1; d1_vs = 1'b1; d2_vs = 1'b1;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        bg[r][c] = 8'd1;
    bg[11][16] = 8'd2;
    mx = -20; my = -20;
    gx = 50;  gy = 50;
    g2x = 80; g2y = 10;

    repeat (3) begin
      check_outputs();
      advance(1'b1);
    end

    // Frame 0: static map, no sprites on screen yet; sync/pulse accounting
    repeat (FRAME) begin
      check_outputs();
      advance(1'b0);
    end

    // Frame 1: sprites from snapshot, random map edits, mid-frame mario move
    repeat (FRAME) begin
      check_outputs();
      if ($urandom_range(31) == 0) mutate();
      if (t == FRAME + 40 * HT) begin
        mx = 60;
        my = 30;
      end
      advance(1'b0);
    end
    window = 1'b0;
    chk("hsync_low_per_frame", hs_low, VT * HS);
    chk("vsync_low_per_frame", vs_low, VS * HT);
    chk("frame_start_per_frame", fs_cnt, 1);

    // Frame 2 up to (30,20), then a one-cycle reset
    while (t < 2 * FRAME + 20 * HT + 30) begin
      check_outputs();
      if ($urandom_range(63) == 0) mutate();
      advance(1'b0);
    end
    check_outputs();
    advance(1'b1);
    mx  = int'($urandom_range(150)) - 50;
    my  = int'($urandom_range(120)) - 50;
    gx  = int'($urandom_range(150)) - 50;
    gy  = int'($urandom_range(120)) - 50;
    g2x = int'($urandom_range(150)) - 50;
    g2y = int'($urandom_range(120)) - 50;

    // Restarted raster: one blank-sprite frame, then randomized sprites
    repeat (FRAME + 30 * HT) begin
      check_outputs();
      if ($urandom_range(31) == 0) mutate();
      advance(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
